cpu_ifetch_wb: RTL and testbench

- Instruction prefetch unit directly upstream of cpu_fetch.
- Acts as a Wishbone classic read master: fetches sequential 32-bit instruction words from memory into a small prefetch FIFO.
- Presents the FIFO head (word plus its address) to the fetch stage through a valid/read handshake.
- A redirect (flush) from the pipeline empties the queue and restarts fetching at a new address.

---
 rtl/cpu_ifetch_wb.sv | 187 ++++++++++++++++++
 tb/tb_cpu_ifetch_wb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ifetch_wb.sv
// cpu_ifetch_wb: instruction prefetch unit upstream of cpu_fetch.
// Wishbone classic read master that fills a small FIFO with sequential
// 32-bit instruction words. The fetch stage sees the FIFO head through a
// valid/read handshake. A flush empties the queue and restarts fetching at a
// new address without aborting a classic cycle that is already in flight.
`timescale 1ns/1ps

module cpu_ifetch_wb #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00001000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        rd_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [31:0] pc_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // IDLE: no cycle open. BUS: fetching for the queue.
    // DRAIN: waiting out a cycle whose data was invalidated by a flush.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   dat_mem [DEPTH];
    logic [31:0]   pc_mem  [DEPTH];

    logic          push;
    logic          pop;
    logic          xfer_done;
    logic [31:0]   flush_pc;
    logic [31:0]   pc_inc;
    logic [CW-1:0] count_pp;

    // Next-state, bus-request and FIFO bookkeeping logic.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        adr_d      = adr_q;
        fetch_pc_d = fetch_pc_q;
        err_d      = err_q;

        // Bits [1:0] of the redirect target are forced to zero.
        flush_pc  = flush_pc_i & ~32'h3;
        pc_inc    = fetch_pc_q + 32'd4;
        xfer_done = wb_ack_i | wb_err_i;

        // A flush voids any same-cycle push or pop; an error never pushes.
        pop      = rd_i & (count_q != '0) & ~flush_i;
        push     = (state_q == BUS) & wb_ack_i & ~wb_err_i & ~flush_i;
        count_pp = count_q + CW'(push) - CW'(pop);

        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    fetch_pc_d = flush_pc;
                    err_d      = 1'b0;
                    cyc_d      = 1'b1;
                    adr_d      = flush_pc;
                    state_d    = BUS;
                end else if ((count_q < FULL) && !err_q) begin
                    cyc_d   = 1'b1;
                    adr_d   = fetch_pc_q;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (flush_i) begin
                    fetch_pc_d = flush_pc;
                    err_d      = 1'b0;
                    if (xfer_done) begin
                        // Returned data is stale; start the new stream at once.
                        adr_d = flush_pc;
                    end else begin
                        // Classic cycles cannot be aborted: keep cyc and address.
                        state_d = DRAIN;
                    end
                end else if (wb_err_i) begin
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end else if (wb_ack_i) begin
                    fetch_pc_d = pc_inc;
                    adr_d      = pc_inc;
                    if (count_pp >= FULL) begin
                        cyc_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    fetch_pc_d = flush_pc;
                    err_d      = 1'b0;
                end
                if (xfer_done) begin
                    // Data or error of the invalidated cycle is discarded.
                    adr_d   = fetch_pc_d;
                    state_d = BUS;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_pp;
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
        end
    end

    // Control and address registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            adr_q      <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            err_q      <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            adr_q      <= adr_d;
            fetch_pc_q <= fetch_pc_d;
            err_q      <= err_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; entries only become visible through count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            dat_mem[wr_ptr_q] <= wb_dat_i;
            pc_mem[wr_ptr_q]  <= fetch_pc_q;
        end
    end

    assign valid_o  = (count_q != '0);
    assign data_o   = valid_o ? dat_mem[rd_ptr_q] : 32'h0;
    assign pc_o     = valid_o ? pc_mem[rd_ptr_q]  : 32'h0;
    assign err_o    = err_q;
    assign wb_adr_o = adr_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = 1'b0;

endmodule

// File: tb/tb_cpu_ifetch_wb.sv
// Testbench for cpu_ifetch_wb: per-cycle vector tables plus a scoreboard of
// expected fetch addresses that is consumed whenever the consumer pops.
`timescale 1ns/1ps

module tb_cpu_ifetch_wb;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        fl;
        logic [31:0] fpc;
        logic        mack;
        logic [31:0] sbv;   // nonzero: push this expected pc to the scoreboard
        logic        ec;    // expected cyc/stb
        logic [31:0] ea;    // expected address (checked when ec=1)
        logic        ev;    // expected valid
        logic [31:0] ep;    // expected pc (data equals pc for this slave)
        logic        ee;    // expected err
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = 32'h0;
    logic        rd_i = 1'b0;
    logic        valid_o;
    logic [31:0] data_o;
    logic [31:0] pc_o;
    logic        err_o;
    logic [31:0] wb_adr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    // Slave model controls
    logic        auto_m  = 1'b1;
    int          waits   = 0;
    logic [31:0] err_adr = 32'hFFFF_FFFF;
    logic        man_ack = 1'b0;
    int          wcnt    = 0;

    int checks = 0;
    int errors = 0;
    vec_t rows[$];
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    cpu_ifetch_wb #(.DEPTH(4), .RESET_PC(32'h00001000)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .rd_i       (rd_i),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .pc_o       (pc_o),
        .err_o      (err_o),
        .wb_adr_o   (wb_adr_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_sel_o   (wb_sel_o),
        .wb_we_o    (wb_we_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    // Memory model: each word holds its own byte address.
    wire auto_hit = wb_cyc_o & wb_stb_o & (wcnt == waits);
    assign wb_ack_i = auto_m ? (auto_hit & (wb_adr_o != err_adr)) : man_ack;
    assign wb_err_i = auto_m & auto_hit & (wb_adr_o == err_adr);
    assign wb_dat_i = wb_adr_o;

    // Wait-state counter of the slave
    always @(posedge clk) begin
        if (wb_cyc_o && !(wb_ack_i || wb_err_i)) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic rd, input logic fl,
                                input logic [31:0] fpc, input logic mack,
                                input logic [31:0] sbv, input logic ec,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic ee);
        vec_t v;
        v.rst = rst; v.rd = rd; v.fl = fl; v.fpc = fpc; v.mack = mack;
        v.sbv = sbv; v.ec = ec; v.ea = ea; v.ev = ev; v.ep = ep; v.ee = ee;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; rd_i = 1'b0; flush_i = 1'b0; man_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst cyc",   {31'b0, wb_cyc_o}, 32'h0);
        chk("rst stb",   {31'b0, wb_stb_o}, 32'h0);
        chk("rst valid", {31'b0, valid_o},  32'h0);
        chk("rst data",  data_o,            32'h0);
        chk("rst pc",    pc_o,              32'h0);
        chk("rst err",   {31'b0, err_o},    32'h0);
        chk("rst adr",   wb_adr_o,          32'h00001000);
        chk("sel",       {28'b0, wb_sel_o}, 32'hF);
        chk("we",        {31'b0, wb_we_o},  32'h0);
        sb.delete();
    endtask

    task automatic run_rows(input string tname);
        logic [31:0] e;
        foreach (rows[i]) begin
            @(negedge clk);
            rst_i = rows[i].rst; rd_i = rows[i].rd; flush_i = rows[i].fl;
            flush_pc_i = rows[i].fpc; man_ack = rows[i].mack;
            #1;
            if (rows[i].rst || rows[i].fl) begin
                sb.delete();
            end else if (rows[i].rd && valid_o) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s[%0d] pop: got pc %h, scoreboard empty", tname, i, pc_o);
                end else begin
                    checks--;
                    e = sb.pop_front();
                    chk($sformatf("%s[%0d] sb pc", tname, i), pc_o, e);
                    chk($sformatf("%s[%0d] sb data", tname, i), data_o, e);
                end
            end
            if (rows[i].sbv != 32'h0) sb.push_back(rows[i].sbv);
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d] cyc", tname, i), {31'b0, wb_cyc_o}, {31'b0, rows[i].ec});
            chk($sformatf("%s[%0d] stb", tname, i), {31'b0, wb_stb_o}, {31'b0, rows[i].ec});
            if (rows[i].ec)
                chk($sformatf("%s[%0d] adr", tname, i), wb_adr_o, rows[i].ea);
            chk($sformatf("%s[%0d] valid", tname, i), {31'b0, valid_o}, {31'b0, rows[i].ev});
            chk($sformatf("%s[%0d] pc", tname, i), pc_o, rows[i].ev ? rows[i].ep : 32'h0);
            chk($sformatf("%s[%0d] data", tname, i), data_o, rows[i].ev ? rows[i].ep : 32'h0);
            chk($sformatf("%s[%0d] err", tname, i), {31'b0, err_o}, {31'b0, rows[i].ee});
        end
    endtask

    initial begin
        // Fill to full, single-pop refill, then one word per cycle streaming.
        auto_m = 1'b1; waits = 0; err_adr = 32'hFFFF_FFFF;
        do_reset();
        for (int k = 0; k < 16; k++) sb.push_back(32'h1000 + 32'(4 * k));
        rows.delete();
        //                 rst  rd  fl  fpc mack sbv  ec  ea          ev  ep          ee
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1004, 1, 32'h1000, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1008, 1, 32'h1000, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h100C, 1, 32'h1000, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,    1, 32'h1000, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,    1, 32'h1000, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,    1, 32'h1004, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h1010, 1, 32'h1004, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,    1, 32'h1004, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,    1, 32'h1004, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,    1, 32'h1008, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h1014, 1, 32'h100C, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h1018, 1, 32'h1010, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h101C, 1, 32'h1014, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h1020, 1, 32'h1018, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h1024, 1, 32'h101C, 0));
        run_rows("fill");

        // Flush during the second wait state of a 3-wait-state fetch.
        waits = 3;
        do_reset();
        rows.delete();
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 1, 32'h2002, 0, 32'h2000, 1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h2000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h2000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h2000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h2000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h2004, 1, 32'h2000, 0));
        rows.push_back(mk(0, 1, 0, 0,        0, 0,        1, 32'h2004, 0, 32'h0,    0));
        run_rows("drain");

        // Flush coincident with ack and rd.
        waits = 0;
        do_reset();
        sb.push_back(32'h1000);
        rows.delete();
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h1004, 1, 32'h1000, 0));
        rows.push_back(mk(0, 1, 1, 32'h4000, 0, 32'h4000, 1, 32'h4000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h4004, 1, 32'h4000, 0));
        rows.push_back(mk(0, 1, 0, 0,        0, 0,        1, 32'h4008, 1, 32'h4004, 0));
        run_rows("flushack");

        // Bus error on the second fetch, then recovery through a flush.
        err_adr = 32'h1004;
        do_reset();
        sb.push_back(32'h1000);
        rows.delete();
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h1004, 1, 32'h1000, 0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        0, 32'h0,    1, 32'h1000, 1));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        0, 32'h0,    1, 32'h1000, 1));
        rows.push_back(mk(0, 1, 0, 0,        0, 0,        0, 32'h0,    0, 32'h0,    1));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        0, 32'h0,    0, 32'h0,    1));
        rows.push_back(mk(0, 0, 1, 32'h3000, 0, 32'h3000, 1, 32'h3000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0,        0, 0,        1, 32'h3004, 1, 32'h3000, 0));
        rows.push_back(mk(0, 1, 0, 0,        0, 32'h3004, 1, 32'h3008, 1, 32'h3004, 0));
        run_rows("buserr");
        err_adr = 32'hFFFF_FFFF;

        // Reset in the middle of a cycle, followed by a late ack.
        auto_m = 1'b0;
        do_reset();
        rows.delete();
        rows.push_back(mk(0, 0, 0, 0, 0, 0,        1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0,        1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(1, 0, 0, 0, 0, 0,        0, 32'h0,    0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0, 1, 0,        1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0,        1, 32'h1000, 0, 32'h0,    0));
        rows.push_back(mk(0, 0, 0, 0, 1, 32'h1000, 1, 32'h1004, 1, 32'h1000, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0,        1, 32'h1004, 0, 32'h0,    0));
        run_rows("rstbus");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
